game_round_sequencer: RTL and testbench
=======================================

// Module: game_round_sequencer
// PURPOSE
//   Sequences successive rounds of the torpedo game above the master FSM.
//   - Turns the raw launch key into a single-cycle launch pulse.
//   - Tallies hits and misses, and raises target difficulty as the player scores.
//   - Declares game over after MAX_MISSES misses.
//   - Drives target_speedup of game_top and the launch input of the master FSM.
// PARAMETERS
//   SCORE_W        8  width of score/hit counters; score saturates at 2**SCORE_W-1
//   MISS_W         3  width of miss counter
//   MAX_MISSES     3  misses that end the game (1..2**MISS_W-1)
//   HITS_PER_LEVEL 4  consecutive hits that advance difficulty one level (>=1)
// PORTS
//   clk            in   1        system clock
//   rst            in   1        synchronous reset, active-high
//   launch_key     in   1        raw launch key level (already synchronised)
//   round_end      in   1        1-cycle pulse from master FSM (end_of_game_timer_start)
//   game_won       in   1        master FSM level; valid in the cycle round_end=1
//   timer_running  in   1        end_of_game_timer_running
//   launch         out  1        1-cycle launch pulse to master FSM
//   target_speedup out  2        difficulty code to game_top (00,01,10 only)
//   score          out  SCORE_W  total hits this game
//   misses         out  MISS_W   misses this game
//   round_active   out  1        1 while in ROUND or RESULT
//   game_over      out  1        1 while in OVER
// BEHAVIOUR
//   Reset values:
//   - all outputs are 0; state is IDLE.
//   - streak and level are 0.
//   - key_q is 1, so a key held through reset does not launch.
//   Key edge: key_rise = launch_key & ~key_q, where key_q is launch_key registered each cycle.
//   States:
//   - IDLE:
//     - key_rise & ~timer_running -> launch=1 in the next cycle; state ROUND.
//     - key_rise while timer_running is ignored and not queued.
//   - ROUND:
//     - Waits for round_end, then samples game_won into won_q; state RESULT.
//     - launch_key is ignored.
//   - RESULT: waits for timer_running==0. In that cycle:
//     - Hit (won_q=1):
//       - score += 1, saturating; streak += 1.
//       - If streak reaches HITS_PER_LEVEL: streak=0 and level = min(level+1, 2).
//     - Miss (won_q=0):
//       - streak=0; level is unchanged; misses += 1.
//       - If the new misses == MAX_MISSES, next state is OVER.
//     - Otherwise the next state is IDLE.
//   - OVER:
//     - All counters are frozen; game_over=1.
//     - key_rise -> score, misses, streak and level are cleared; state IDLE with no launch.
//       The player must press again to launch.
//   Timing:
//   - launch latency is exactly 1 cycle after the key_rise cycle.
//   - launch is never asserted two cycles in a row.
//   - Counter updates are visible 1 cycle after the RESULT exit cycle.
//   - target_speedup = level[1:0], registered and changed only on the RESULT exit.
//     Code 2'b11 (target stopped) is never driven.
//   round_end in IDLE or OVER is ignored, as a protocol error.
//   If round_end and timer_running fall in the same cycle in ROUND, RESULT still takes 1 cycle:
//   - RESULT sees timer_running=0 on its first cycle and exits then.
//   rst mid-round returns to the reset values in the next cycle; no launch is emitted.
// TESTING
//   1. Reset with launch_key=1, release, press -> exactly one launch pulse.
//      The pulse comes 1 cycle after the press edge, not at release from reset.
//   2. Launch, round_end with game_won=1, timer_running 1 for 10 cycles then 0:
//      - score=1 one cycle after the timer falls; misses=0; back in IDLE.
//   3. Four hit rounds (HITS_PER_LEVEL=4) -> target_speedup goes 00->01 after the 4th.
//      Eight more hits -> 10, and it stays 10 (saturation).
//   4. Three miss rounds -> misses=3 and game_over=1.
//      A further press clears the counters, enters IDLE, and emits no launch.
//      The next press launches.
//   5. Press while timer_running=1 in IDLE -> no launch.
//      Press again after the timer falls -> launch.
//   6. Assert rst while in ROUND -> next cycle: state IDLE, all outputs 0.
//      A round_end pulse arriving afterwards has no effect.

Source files
------------

// File: rtl/game_round_sequencer.sv
// Round sequencer for the torpedo game: turns the launch key into a single
// launch pulse, runs one round at a time above the master FSM, tallies
// hits/misses, raises target difficulty on hit streaks and ends the game
// after a fixed number of misses.
module game_round_sequencer #(
  parameter int SCORE_W        = 8,
  parameter int MISS_W         = 3,
  parameter int MAX_MISSES     = 3,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch_key,
  input  logic               round_end,
  input  logic               game_won,
  input  logic               timer_running,
  output logic               launch,
  output logic [1:0]         target_speedup,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic               round_active,
  output logic               game_over
);

  // Wide enough to hold HITS_PER_LEVEL itself.
  localparam int STREAK_W = $clog2(HITS_PER_LEVEL + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_RESULT = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic                key_q,    key_d;
  logic                launch_q, launch_d;
  logic                won_q,    won_d;
  logic [SCORE_W-1:0]  score_q,  score_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [1:0]          level_q,  level_d;

  logic                key_rise;
  logic [STREAK_W-1:0] streak_inc;
  logic [MISS_W-1:0]   misses_inc;

  assign key_rise   = launch_key & ~key_q;
  assign streak_inc = streak_q + STREAK_W'(1);
  assign misses_inc = misses_q + MISS_W'(1);

  // State and counter registers; key_q resets high so a key held through
  // reset is not seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= 1'b1;
      launch_q <= 1'b0;
      won_q    <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
      streak_q <= '0;
      level_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q  <= state_d;
      key_q    <= key_d;
      launch_q <= launch_d;
      won_q    <= won_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      streak_q <= streak_d;
      level_q  <= level_d;
    end
  end

  // Next-state, launch generation and end-of-round bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d  = state_q;
    key_d    = launch_key;
    launch_d = 1'b0;
    won_d    = won_q;
    score_d  = score_q;
    misses_d = misses_q;
    streak_d = streak_q;
    level_d  = level_q;

    unique case (state_q)
      S_IDLE: begin
        // A press while the end-of-game timer runs is dropped, not queued.
        if (key_rise && !timer_running) begin
          launch_d = 1'b1;
          state_d  = S_ROUND;
        end
      end

      S_ROUND: begin
        if (round_end) begin
          won_d   = game_won;
          state_d = S_RESULT;
        end
      end

      S_RESULT: begin
        if (!timer_running) begin
          state_d = S_IDLE;
          if (won_q) begin
            if (score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + SCORE_W'(1);
            end
            if (streak_inc == STREAK_W'(HITS_PER_LEVEL)) begin
              streak_d = '0;
              // Level 3 would stop the target, so difficulty tops out at 2.
              if (level_q != 2'd2) begin
                level_d = level_q + 2'd1;
              end
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            streak_d = '0;
            misses_d = misses_inc;
            if (misses_inc == MISS_W'(MAX_MISSES)) begin
              state_d = S_OVER;
            end
          end
        end
      end

      S_OVER: begin
        // The clearing press only starts a new game; launching takes another.
        if (key_rise) begin
          score_d  = '0;
          misses_d = '0;
          streak_d = '0;
          level_d  = 2'd0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign launch         = launch_q;
  assign target_speedup = level_q;
  assign score          = score_q;
  assign misses         = misses_q;
  assign round_active   = (state_q == S_ROUND) || (state_q == S_RESULT);
  assign game_over      = (state_q == S_OVER);

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: expected launch cycles and end-of-round
// counter values are queued as stimulus is driven and compared when the DUT
// is due to produce them.
module tb_game_round_sequencer;

  localparam int SCORE_W        = 8;
  localparam int MISS_W         = 3;
  localparam int MAX_MISSES     = 3;
  localparam int HITS_PER_LEVEL = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               launch_key = 1'b0;
  logic               round_end = 1'b0;
  logic               game_won = 1'b0;
  logic               timer_running = 1'b0;
  logic               launch;
  logic [1:0]         target_speedup;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               round_active;
  logic               game_over;

  game_round_sequencer #(
    .SCORE_W(SCORE_W), .MISS_W(MISS_W),
    .MAX_MISSES(MAX_MISSES), .HITS_PER_LEVEL(HITS_PER_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .launch_key(launch_key), .round_end(round_end),
    .game_won(game_won), .timer_running(timer_running), .launch(launch),
    .target_speedup(target_speedup), .score(score), .misses(misses),
    .round_active(round_active), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int failed    = 0;

  typedef struct {
    logic [SCORE_W-1:0] score;
    logic [MISS_W-1:0]  misses;
    logic [1:0]         speed;
    logic               over;
  } exp_t;

  int   launch_q[$];   // cycle numbers at which launch must be seen
  exp_t result_q[$];   // counter values expected after each round

  // Reference model of the game counters.
  int m_score = 0, m_misses = 0, m_streak = 0, m_level = 0;

  function automatic exp_t model_round(input logic won);
    exp_t e;
    if (won) begin
      if (m_score < (1 << SCORE_W) - 1) m_score++;
      m_streak++;
      if (m_streak == HITS_PER_LEVEL) begin
        m_streak = 0;
        if (m_level < 2) m_level++;
      end
    end else begin
      m_streak = 0;
      m_misses++;
    end
    e.score  = SCORE_W'(m_score);
    e.misses = MISS_W'(m_misses);
    e.speed  = 2'(m_level);
    e.over   = (m_misses == MAX_MISSES);
    return e;
  endfunction

  function automatic void model_clear();
    m_score = 0; m_misses = 0; m_streak = 0; m_level = 0;
  endfunction

  // Launch monitor: every pulse must match the queued cycle, none may be missed.
  always @(negedge clk) begin
    if (launch_q.size() > 0 && launch_q[0] < cyc) begin
      tests_run++; failed++;
      $display("FAIL launch_missing: no launch at cycle %0d (now %0d)", launch_q[0], cyc);
      void'(launch_q.pop_front());
    end
    if (launch === 1'b1) begin
      tests_run++;
      if (launch_q.size() == 0) begin
        failed++;
        $display("FAIL launch_unexpected: launch=1 at cycle %0d, none expected", cyc);
      end else begin
        if (launch_q[0] !== cyc) begin
          failed++;
          $display("FAIL launch_cycle: got cycle %0d, expected %0d", cyc, launch_q[0]);
        end
        void'(launch_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle key press; queue a launch one cycle later when one is due.
  task automatic press(input logic expect_launch);
    @(negedge clk);
    launch_key = 1'b1;
    if (expect_launch) launch_q.push_back(cyc + 1);
    @(negedge clk);
    launch_key = 1'b0;
  endtask

  task automatic expect_all_zero(input string name);
    tests_run++;
    if ({launch, target_speedup, score, misses, round_active, game_over} !== '0) begin
      failed++;
      $display("FAIL %s: launch=%b speed=%b score=%0d misses=%0d active=%b over=%b, expected all 0",
               name, launch, target_speedup, score, misses, round_active, game_over);
    end
  endtask

  // Launch, end the round, hold the timer tcycles, then compare the counters
  // one cycle after the RESULT exit.
  task automatic play_round(input logic won, input int tcycles, input string name);
    exp_t e;
    press(1'b1);
    tests_run++;
    if (round_active !== 1'b1) begin
      failed++;
      $display("FAIL %s_active: round_active=%b, expected 1", name, round_active);
    end
    @(negedge clk);
    round_end     = 1'b1;
    game_won      = won;
    timer_running = (tcycles > 0);
    result_q.push_back(model_round(won));
    @(negedge clk);
    round_end = 1'b0;
    game_won  = 1'b0;
    if (tcycles > 0) begin
      repeat (tcycles - 1) @(negedge clk);
      tests_run++;
      if (round_active !== 1'b1) begin
        failed++;
        $display("FAIL %s_result_wait: round_active=%b, expected 1", name, round_active);
      end
      timer_running = 1'b0;
    end
    @(negedge clk);
    e = result_q.pop_front();
    tests_run++;
    if (score !== e.score || misses !== e.misses || target_speedup !== e.speed ||
        game_over !== e.over || round_active !== 1'b0) begin
      failed++;
      $display("FAIL %s: score=%0d misses=%0d speed=%b over=%b active=%b, expected score=%0d misses=%0d speed=%b over=%b active=0",
               name, score, misses, target_speedup, game_over, round_active,
               e.score, e.misses, e.speed, e.over);
    end
  endtask

  task automatic test_reset();
    launch_key = 1'b1;
    rst = 1'b1;
    tick(3);
    expect_all_zero("reset_values");
    rst = 1'b0;
    tick(3);  // key still held: no launch allowed
    expect_all_zero("key_held_through_reset");
    launch_key = 1'b0;
    // round_end while idle is a protocol error and must be ignored.
    @(negedge clk);
    round_end = 1'b1; game_won = 1'b1;
    @(negedge clk);
    round_end = 1'b0; game_won = 1'b0;
    tick(2);
    expect_all_zero("round_end_in_idle");
  endtask

  task automatic test_first_hit();
    play_round(1'b1, 10, "first_hit");
  endtask

  task automatic test_levels();
    for (int i = 0; i < 3; i++) play_round(1'b1, 2, "hit_to_level1");
    tests_run++;
    if (target_speedup !== 2'b01) begin
      failed++;
      $display("FAIL level1: speed=%b, expected 01", target_speedup);
    end
    for (int i = 0; i < 8; i++) play_round(1'b1, 1 + (i % 3), "hit_to_level2");
    for (int i = 0; i < 4; i++) play_round(1'b1, 2, "hit_saturated");
    tests_run++;
    if (target_speedup !== 2'b10) begin
      failed++;
      $display("FAIL level_saturate: speed=%b, expected 10", target_speedup);
    end
  endtask

  task automatic test_timer_block();
    timer_running = 1'b1;
    press(1'b0);
    tick(2);
    tests_run++;
    if (round_active !== 1'b0) begin
      failed++;
      $display("FAIL timer_block: round_active=%b, expected 0", round_active);
    end
    timer_running = 1'b0;
    play_round(1'b0, 3, "miss_after_timer");
  endtask

  task automatic test_same_cycle();
    play_round(1'b0, 0, "miss_same_cycle");
  endtask

  task automatic test_game_over();
    play_round(1'b0, 2, "miss_game_over");
    tick(2);
    tests_run++;
    if (game_over !== 1'b1 || misses !== 3'(MAX_MISSES) || score !== 8'd16) begin
      failed++;
      $display("FAIL over_frozen: over=%b misses=%0d score=%0d, expected 1/%0d/16",
               game_over, misses, score, MAX_MISSES);
    end
    press(1'b0);
    model_clear();
    tick(1);
    expect_all_zero("over_cleared");
    press(1'b1);  // leaves the DUT in ROUND for the reset test
    tests_run++;
    if (round_active !== 1'b1) begin
      failed++;
      $display("FAIL relaunch: round_active=%b, expected 1", round_active);
    end
  endtask

  task automatic test_rst_mid_round();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_all_zero("rst_mid_round");
    round_end = 1'b1; game_won = 1'b1;
    @(negedge clk);
    round_end = 1'b0; game_won = 1'b0;
    tick(3);
    expect_all_zero("round_end_after_rst");
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_levels();
    test_timer_block();
    test_same_cycle();
    test_game_over();
    test_rst_mid_round();
    tick(3);
    tests_run++;
    if (launch_q.size() != 0 || result_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d launches and %0d results outstanding, expected 0",
               launch_q.size(), result_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
